// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared FSM encodings, default widths and MEM/WB bubble constants
package mem_stage_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;
endpackage

// File: rtl/mem_stage_wb_register.sv
// rtl/mem_stage_wb_register.sv - MEM/WB pipeline register; bubble clears controls, holds data
module mem_wb_register
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_W-1:0]  write_reg,
  output logic              mem_to_reg,
  output logic              reg_write
);
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              reg_write_q, reg_write_d;

  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    if (load) begin
      read_data_d  = read_data_in;
      alu_result_d = alu_result_in;
      write_reg_d  = write_reg_in;
      mem_to_reg_d = mem_to_reg_in;
      reg_write_d  = reg_write_in;
    end else if (bubble) begin
      // Data fields keep their old value; only the controls are squashed.
      mem_to_reg_d = BUBBLE_MEMTOREG;
      reg_write_d  = BUBBLE_REGWRITE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign read_data  = read_data_q;
  assign alu_result = alu_result_q;
  assign write_reg  = write_reg_q;
  assign mem_to_reg = mem_to_reg_q;
  assign reg_write  = reg_write_q;
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: dmem req/ack FSM with timeout, branch resolve, MEM/WB
// Optional MEM_ALIGN_CHECK_EN drops word-misaligned accesses and pulses mem_misalign.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] EX_MEM_ALUResult,
  input  logic [DATA_W-1:0] EX_MEM_ReadData2,
  input  logic [REG_W-1:0]  EX_MEM_WriteReg,
  input  logic              EX_MEM_Zero,
  input  logic              EX_MEM_Branch,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemToReg,
  input  logic              EX_MEM_RegWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              PCSrc,
  output logic              mem_error,
  output logic              mem_misalign,
  output logic [DATA_W-1:0] MEM_WB_ReadData,
  output logic [DATA_W-1:0] MEM_WB_ALUResult,
  output logic [REG_W-1:0]  MEM_WB_WriteReg,
  output logic              MEM_WB_MemToReg,
  output logic              MEM_WB_RegWrite
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_error_q, mem_error_d;
  logic              access, misalign, eff_access, abort, stall_raw, wb_load;
  logic [DATA_W-1:0] wb_read_data;

  assign access = EX_MEM_MemRead | EX_MEM_MemWrite;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (|EX_MEM_ALUResult[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign eff_access = access & ~misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (eff_access && !dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
          // The counter already includes the IDLE request cycle.
          abort   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_error_d = mem_error_q | abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Reset gates the combinational handshake so an open access is dropped at once.
  assign dmem_req     = rst & (eff_access | (state_q == ST_WAIT));
  assign dmem_we      = EX_MEM_MemWrite;
  assign dmem_addr    = EX_MEM_ALUResult[ADDR_W-1:0];
  assign dmem_wdata   = EX_MEM_ReadData2;
  assign stall_raw    = eff_access & ~dmem_ack & ~abort;
  assign mem_stall    = rst & stall_raw;
  assign PCSrc        = EX_MEM_Branch & EX_MEM_Zero;
  assign mem_error    = mem_error_q;
  assign mem_misalign = misalign;

  assign wb_load      = ~stall_raw & ~abort & ~misalign;
  assign wb_read_data = (EX_MEM_MemRead & ~EX_MEM_MemWrite & dmem_ack) ? dmem_rdata : '0;

  mem_wb_register #(
    .DATA_W(DATA_W),
    .REG_W (REG_W)
  ) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .load         (wb_load),
    .bubble       (~wb_load),
    .read_data_in (wb_read_data),
    .alu_result_in(EX_MEM_ALUResult),
    .write_reg_in (EX_MEM_WriteReg),
    .mem_to_reg_in(EX_MEM_MemToReg),
    .reg_write_in (EX_MEM_RegWrite),
    .read_data    (MEM_WB_ReadData),
    .alu_result   (MEM_WB_ALUResult),
    .write_reg    (MEM_WB_WriteReg),
    .mem_to_reg   (MEM_WB_MemToReg),
    .reg_write    (MEM_WB_RegWrite)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (TIMEOUT=4)
module tb_mem_stage;
  logic        clk, rst_n;
  logic [31:0] alu_result, read_data2, dmem_rdata;
  logic [4:0]  write_reg;
  logic        zero, branch, mem_read, mem_write, mem_to_reg, reg_write, dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, pcsrc, mem_error, mem_misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;
  logic        wb_mem_to_reg, wb_reg_write;
  int          tests, fails;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst_n),
    .EX_MEM_ALUResult(alu_result), .EX_MEM_ReadData2(read_data2), .EX_MEM_WriteReg(write_reg),
    .EX_MEM_Zero(zero), .EX_MEM_Branch(branch), .EX_MEM_MemRead(mem_read),
    .EX_MEM_MemWrite(mem_write), .EX_MEM_MemToReg(mem_to_reg), .EX_MEM_RegWrite(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall), .PCSrc(pcsrc),
    .mem_error(mem_error), .mem_misalign(mem_misalign),
    .MEM_WB_ReadData(wb_read_data), .MEM_WB_ALUResult(wb_alu_result),
    .MEM_WB_WriteReg(wb_write_reg), .MEM_WB_MemToReg(wb_mem_to_reg), .MEM_WB_RegWrite(wb_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    alu_result = '0; read_data2 = '0; write_reg = '0; zero = 1'b0; branch = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h10;
    #1;
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", dmem_req); end
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b want 0", mem_stall); end
    tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL reset_error got %0b want 0", mem_error); end
    tests++; if ({wb_read_data, wb_alu_result, wb_write_reg, wb_mem_to_reg, wb_reg_write} !== '0) begin
      fails++; $display("FAIL reset_memwb got %0h/%0h/%0h/%0b/%0b want all 0",
                        wb_read_data, wb_alu_result, wb_write_reg, wb_mem_to_reg, wb_reg_write);
    end
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait_load(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    @(negedge clk);
    mem_read = 1'b1; alu_result = addr; write_reg = rd; mem_to_reg = 1'b1; reg_write = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = data;
    #1;
    tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin fails++; $display("FAIL zw_req req=%0b we=%0b want 1/0", dmem_req, dmem_we); end
    tests++; if (dmem_addr !== addr) begin fails++; $display("FAIL zw_addr got %0h want %0h", dmem_addr, addr); end
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL zw_stall got %0b want 0", mem_stall); end
    @(negedge clk);
    tests++; if (wb_read_data !== data) begin fails++; $display("FAIL zw_rdata got %0h want %0h", wb_read_data, data); end
    tests++; if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_write_reg !== rd) begin
      fails++; $display("FAIL zw_ctrl got rw=%0b m2r=%0b rd=%0d want 1/1/%0d", wb_reg_write, wb_mem_to_reg, wb_write_reg, rd);
    end
    drive_nop();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h100; write_reg = 5'd11; reg_write = 1'b1; mem_to_reg = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    tests++; if (wb_read_data !== 32'h1111_2222 || wb_write_reg !== 5'd11) begin
      fails++; $display("FAIL b2b_first got %0h rd=%0d want 11112222 rd=11", wb_read_data, wb_write_reg);
    end
    alu_result = 32'h104; write_reg = 5'd12; dmem_rdata = 32'h3333_4444;
    #1;
    tests++; if (mem_stall !== 1'b0 || dmem_addr !== 32'h104) begin fails++; $display("FAIL b2b_issue stall=%0b addr=%0h want 0/104", mem_stall, dmem_addr); end
    @(negedge clk);
    tests++; if (wb_read_data !== 32'h3333_4444 || wb_write_reg !== 5'd12) begin
      fails++; $display("FAIL b2b_second got %0h rd=%0d want 33334444 rd=12", wb_read_data, wb_write_reg);
    end
    drive_nop();
  endtask

  task automatic test_wait_store();
    @(negedge clk);
    mem_write = 1'b1; alu_result = 32'h20; read_data2 = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) dmem_ack = 1'b1;
      #1;
      tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h20 || dmem_wdata !== 32'h55) begin
        fails++; $display("FAIL st_hold c%0d req=%0b we=%0b addr=%0h wdata=%0h want 1/1/20/55", c, dmem_req, dmem_we, dmem_addr, dmem_wdata);
      end
      tests++; if (mem_stall !== (c < 4)) begin fails++; $display("FAIL st_stall c%0d got %0b want %0b", c, mem_stall, (c < 4)); end
      tests++; if (wb_reg_write !== 1'b0) begin fails++; $display("FAIL st_regwrite c%0d got %0b want 0", c, wb_reg_write); end
      @(negedge clk);
    end
    tests++; if (wb_reg_write !== 1'b0 || wb_alu_result !== 32'h20 || wb_read_data !== 32'h0) begin
      fails++; $display("FAIL st_done rw=%0b alu=%0h rdata=%0h want 0/20/0", wb_reg_write, wb_alu_result, wb_read_data);
    end
    tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL st_error got %0b want 0", mem_error); end
    drive_nop();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    alu_result = 32'h99; write_reg = 5'd2; reg_write = 1'b1;
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h40; write_reg = 5'd7; mem_to_reg = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL to_req c%0d got %0b want 1", c, dmem_req); end
      tests++; if (mem_stall !== (c < 4)) begin fails++; $display("FAIL to_stall c%0d got %0b want %0b", c, mem_stall, (c < 4)); end
      tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL to_err_early c%0d got %0b want 0", c, mem_error); end
      tests++; if (wb_reg_write !== (c == 1)) begin fails++; $display("FAIL to_wb_rw c%0d got %0b want %0b", c, wb_reg_write, (c == 1)); end
      @(negedge clk);
    end
    drive_nop();
    #1;
    tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL to_error got %0b want 1", mem_error); end
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL to_req_drop got %0b want 0", dmem_req); end
    tests++; if (wb_reg_write !== 1'b0 || wb_mem_to_reg !== 1'b0 || wb_alu_result !== 32'h99 || wb_write_reg !== 5'd2) begin
      fails++; $display("FAIL to_bubble rw=%0b m2r=%0b alu=%0h rd=%0d want 0/0/99/2", wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_write_reg);
    end
    dmem_ack = 1'b1;
    #1;
    tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL stray_ack req=%0b stall=%0b want 0/0", dmem_req, mem_stall); end
    @(negedge clk);
    tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL to_sticky got %0b want 1", mem_error); end
    drive_nop();
  endtask

  task automatic test_branch();
    @(negedge clk);
    branch = 1'b1; zero = 1'b1;
    #1;
    tests++; if (pcsrc !== 1'b1 || dmem_req !== 1'b0) begin fails++; $display("FAIL br_taken pcsrc=%0b req=%0b want 1/0", pcsrc, dmem_req); end
    zero = 1'b0;
    #1;
    tests++; if (pcsrc !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL br_not_taken pcsrc=%0b req=%0b want 0/0", pcsrc, dmem_req); end
    branch = 1'b0; zero = 1'b1;
    #1;
    tests++; if (pcsrc !== 1'b0) begin fails++; $display("FAIL br_nobranch pcsrc=%0b want 0", pcsrc); end
    drive_nop();
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    alu_result = 32'h1234; write_reg = 5'd3; reg_write = 1'b1;
    #1;
    tests++; if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL alu_issue stall=%0b req=%0b want 0/0", mem_stall, dmem_req); end
    @(negedge clk);
    tests++; if (wb_alu_result !== 32'h1234 || wb_reg_write !== 1'b1 || wb_write_reg !== 5'd3 || wb_read_data !== 32'h0 || wb_mem_to_reg !== 1'b0) begin
      fails++; $display("FAIL alu_wb alu=%0h rw=%0b rd=%0d rdata=%0h m2r=%0b want 1234/1/3/0/0",
                        wb_alu_result, wb_reg_write, wb_write_reg, wb_read_data, wb_mem_to_reg);
    end
    drive_nop();
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; alu_result = 32'h30; read_data2 = 32'h77;
    write_reg = 5'd9; reg_write = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_5555;
    #1;
    tests++; if (dmem_we !== 1'b1 || dmem_req !== 1'b1 || mem_stall !== 1'b0) begin
      fails++; $display("FAIL both_issue we=%0b req=%0b stall=%0b want 1/1/0", dmem_we, dmem_req, mem_stall);
    end
    @(negedge clk);
    tests++; if (wb_read_data !== 32'h0 || wb_alu_result !== 32'h30) begin fails++; $display("FAIL both_wb rdata=%0h alu=%0h want 0/30", wb_read_data, wb_alu_result); end
    drive_nop();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    alu_result = 32'hABC; write_reg = 5'd4; reg_write = 1'b1; mem_to_reg = 1'b1;
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h50; write_reg = 5'd8;
    @(negedge clk);
    tests++; if (mem_stall !== 1'b1 || wb_alu_result !== 32'hABC) begin fails++; $display("FAIL rmw_pre stall=%0b alu=%0h want 1/abc", mem_stall, wb_alu_result); end
    rst_n = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL rmw_hs req=%0b stall=%0b want 0/0", dmem_req, mem_stall); end
    tests++; if ({wb_read_data, wb_alu_result, wb_write_reg, wb_mem_to_reg, wb_reg_write} !== '0 || mem_error !== 1'b0) begin
      fails++; $display("FAIL rmw_clear alu=%0h rd=%0d m2r=%0b rw=%0b err=%0b want all 0",
                        wb_alu_result, wb_write_reg, wb_mem_to_reg, wb_reg_write, mem_error);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    drive_nop();
    rst_n = 1'b1;
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h60; dmem_ack = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin fails++; $display("FAIL rmw_restart req=%0b stall=%0b want 1/1", dmem_req, mem_stall); end
    dmem_ack = 1'b1;
    @(negedge clk);
    drive_nop();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    mem_read = 1'b1; alu_result = 32'h13; reg_write = 1'b1; mem_to_reg = 1'b1; dmem_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || mem_misalign !== 1'b1) begin
      fails++; $display("FAIL mis_drop req=%0b stall=%0b mis=%0b want 0/0/1", dmem_req, mem_stall, mem_misalign);
    end
    @(negedge clk);
    drive_nop();
    #1;
    tests++; if (wb_reg_write !== 1'b0 || mem_misalign !== 1'b0) begin fails++; $display("FAIL mis_after rw=%0b mis=%0b want 0/0", wb_reg_write, mem_misalign); end
`else
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD;
    #1;
    tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h13 || mem_misalign !== 1'b0) begin
      fails++; $display("FAIL mis_pass req=%0b addr=%0h mis=%0b want 1/13/0", dmem_req, dmem_addr, mem_misalign);
    end
    @(negedge clk);
    tests++; if (wb_reg_write !== 1'b1 || wb_read_data !== 32'h0BAD) begin fails++; $display("FAIL mis_wb rw=%0b rdata=%0h want 1/bad", wb_reg_write, wb_read_data); end
    drive_nop();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    drive_nop();
    test_reset();
    test_zero_wait_load(32'h10, 32'hDEAD_BEEF, 5'd5);
    test_back_to_back();
    test_wait_store();
    test_timeout();
    test_branch();
    test_alu_op();
    test_read_write_both();
    test_reset_mid_wait();
    test_misalign();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
